// File: rtl/div_iter64_if.sv
// rtl/div_iter64_if.sv - operand/result handshake bundle for div_iter64
//
// Purpose: groups the request side (in_valid/in_ready, operands, is_signed)
// and the response side (out_valid/out_ready, quotient, remainder,
// div_by_zero) of the iterative divider.
// Modports:
//   master - the requester/consumer: drives operands and out_ready
//   slave  - the divider: drives in_ready and the result
interface div_iter64_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, dividend, divisor, is_signed, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, is_signed, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_iter64.sv
// rtl/div_iter64.sv - sequential 64-bit restoring divider (quotient + remainder)
//
// Purpose: one restoring-division iteration per clock, 64 iterations plus one
// sign-fixup cycle; divide-by-zero short-circuits straight to the result.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, aborts any operation in flight
//   bus  - div_iter64_if.slave: in_valid/in_ready, dividend, divisor,
//          is_signed, out_valid/out_ready, quotient, remainder, div_by_zero
// Build option: DIV64_SIGNED_EN - when defined, is_signed selects
// two's-complement division; when undefined every operation is unsigned and
// the sign conversion/negation logic is absent (latency is unchanged).
module div_iter64 #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic           clk,
    input  logic           rst,
    div_iter64_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             div_by_zero_r;

    // dq starts as |dividend| and is shifted left each iteration; its MSB
    // feeds the partial remainder while quotient bits enter at the LSB, so
    // after WIDTH iterations it holds the unsigned quotient.
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;

    // Operand magnitudes and result signs as seen on the accept edge.
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

`ifdef DIV64_SIGNED_EN
    logic neg_q;
    logic neg_r;
    logic a_neg;
    logic b_neg;

    always_comb begin
        a_neg = bus.is_signed & bus.dividend[WIDTH-1];
        b_neg = bus.is_signed & bus.divisor[WIDTH-1];
        abs_a = a_neg ? (~bus.dividend + 1'b1) : bus.dividend;
        abs_b = b_neg ? (~bus.divisor + 1'b1) : bus.divisor;
    end
`else
    logic unused_is_signed;

    assign unused_is_signed = bus.is_signed;
    assign abs_a = bus.dividend;
    assign abs_b = bus.divisor;
`endif

    // The shifted partial remainder can reach 2*|divisor|-1, which needs
    // WIDTH+1 bits; the trial subtraction keeps one more bit as the borrow.
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] trial;
    logic             borrow;

    always_comb begin
        rem_sh = {rem, dq[WIDTH-1]};
        trial  = {1'b0, rem_sh} + ~{2'b00, dvs} + 1'b1;
        borrow = trial[WIDTH+1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            in_ready_r    <= 1'b1;
            out_valid_r   <= 1'b0;
            quotient_r    <= '0;
            remainder_r   <= '0;
            div_by_zero_r <= 1'b0;
            dq            <= '0;
            rem           <= '0;
            dvs           <= '0;
`ifdef DIV64_SIGNED_EN
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        in_ready_r <= 1'b0;
                        if (bus.divisor == '0) begin
                            quotient_r    <= '1;
                            remainder_r   <= bus.dividend;
                            div_by_zero_r <= 1'b1;
                            out_valid_r   <= 1'b1;
                            state         <= DONE;
                        end else begin
                            dq            <= abs_a;
                            dvs           <= abs_b;
                            rem           <= '0;
                            cnt           <= '0;
                            div_by_zero_r <= 1'b0;
`ifdef DIV64_SIGNED_EN
                            neg_q         <= a_neg ^ b_neg;
                            neg_r         <= a_neg;
`endif
                            state         <= CALC;
                        end
                    end
                end

                CALC: begin
                    // On borrow the shifted remainder is below |divisor| and
                    // fits WIDTH bits; otherwise the trial result does.
                    rem <= borrow ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
                    dq  <= {dq[WIDTH-2:0], ~borrow};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end

                FIX: begin
                    // -2^63 / -1 needs no special case: |q| = 2^63 and the
                    // signs agree, so no negation is applied.
`ifdef DIV64_SIGNED_EN
                    quotient_r  <= neg_q ? (~dq + 1'b1) : dq;
                    remainder_r <= neg_r ? (~rem + 1'b1) : rem;
`else
                    quotient_r  <= dq;
                    remainder_r <= rem;
`endif
                    out_valid_r <= 1'b1;
                    state       <= DONE;
                end

                DONE: begin
                    // Returning to IDLE first keeps at least one idle cycle
                    // between a result handshake and the next accept.
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = div_by_zero_r;

endmodule

// File: tb/tb_div_iter64.sv
// tb/tb_div_iter64.sv - scoreboard bench for div_iter64
module tb_div_iter64;

    logic clk;
    logic rst;

    div_iter64_if #(.WIDTH(64)) bus ();

    div_iter64 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic        z;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

`ifdef DIV64_SIGNED_EN
    localparam logic [63:0] M7D2_Q  = 64'hFFFF_FFFF_FFFF_FFFD;
    localparam logic [63:0] M7D2_R  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] OVF_Q   = 64'h8000_0000_0000_0000;
    localparam logic [63:0] OVF_R   = 64'h0;
    localparam logic [63:0] P7DM2_Q = 64'hFFFF_FFFF_FFFF_FFFD;
    localparam logic [63:0] P7DM2_R = 64'h1;
`else
    localparam logic [63:0] M7D2_Q  = 64'h7FFF_FFFF_FFFF_FFFC;
    localparam logic [63:0] M7D2_R  = 64'h1;
    localparam logic [63:0] OVF_Q   = 64'h0;
    localparam logic [63:0] OVF_R   = 64'h8000_0000_0000_0000;
    localparam logic [63:0] P7DM2_Q = 64'h0;
    localparam logic [63:0] P7DM2_R = 64'h7;
`endif

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every result handshake consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result actual=q:%h r:%h required=none",
                         bus.quotient, bus.remainder);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check64("quotient", bus.quotient, e.q);
                check64("remainder", bus.remainder, e.r);
                check64("div_by_zero", {63'd0, bus.div_by_zero}, {63'd0, e.z});
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.in_ready && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) check64("in_ready_timeout", 64'd0, 64'd1);
    endtask

    // hold > 0: keep out_ready low for that many cycles once out_valid rises.
    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                         input logic [63:0] eq, input logic [63:0] er, input logic ez,
                         input int hold);
        exp_t e;
        int   lat;
        e.q = eq;
        e.r = er;
        e.z = ez;
        sb.push_back(e);
        wait_ready();
        bus.out_ready = (hold == 0);
        bus.dividend  = a;
        bus.divisor   = b;
        bus.is_signed = s;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        // Operands are only sampled on the accept edge.
        bus.in_valid = 1'b0;
        bus.dividend = {$urandom, $urandom};
        bus.divisor  = {$urandom, $urandom};
        lat = 1;
        while (!bus.out_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        // Edges counted including the accepting one: accept + 64 CALC + 1 FIX,
        // or the accepting edge alone for a zero divisor.
        check64("latency", 64'(lat), (b == 64'd0) ? 64'd1 : 64'd66);
        if (hold > 0) begin
            bus.in_valid = 1'b1;
            bus.dividend = 64'd5;
            bus.divisor  = 64'd0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check64("hold_out_valid", {63'd0, bus.out_valid}, 64'd1);
                check64("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
                check64("hold_quotient", bus.quotient, eq);
                check64("hold_remainder", bus.remainder, er);
            end
            @(posedge clk);
            #1;
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check64("post_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check64("post_in_ready", {63'd0, bus.in_ready}, 64'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.is_signed = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check64("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check64("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check64("rst_quotient", bus.quotient, 64'd0);
        check64("rst_remainder", bus.remainder, 64'd0);
        check64("rst_dbz", {63'd0, bus.div_by_zero}, 64'd0);

        do_op(64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 1'b0, 0);
        do_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, M7D2_Q, M7D2_R, 1'b0, 0);
        do_op(64'h1234, 64'd0, 1'b0, ONES, 64'h1234, 1'b0 | 1'b1, 0);
        do_op(64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1'b1, ONES, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 0);
        do_op(64'h8000_0000_0000_0000, ONES, 1'b1, OVF_Q, OVF_R, 1'b0, 0);
        do_op(64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, P7DM2_Q, P7DM2_R, 1'b0, 0);
        do_op(ONES, ONES, 1'b0, 64'd1, 64'd0, 1'b0, 0);
        do_op(ONES, 64'h8000_0000_0000_0001, 1'b0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFE, 1'b0, 0);
        do_op(64'd1000, 64'd10, 1'b0, 64'd100, 64'd0, 1'b0, 10);

        // Abort an operation at iteration 30; nothing may come out of it.
        wait_ready();
        bus.dividend  = ONES;
        bus.divisor   = 64'd3;
        bus.is_signed = 1'b0;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check64("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check64("abort_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check64("abort_quotient", bus.quotient, 64'd0);
        check64("abort_remainder", bus.remainder, 64'd0);
        do_op(ONES, 64'h10, 1'b0, 64'h0FFF_FFFF_FFFF_FFFF, 64'hF, 1'b0, 0);

        repeat (80) @(posedge clk);
        check64("scoreboard_drain", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
